// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err,
   output logic [15:0] words_loaded
);

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t      state, state_next;
   logic [15:0] len_reg;
   logic [15:0] word_cnt;
   logic [1:0]  byte_idx;
   logic [23:0] word_sr;
   logic [7:0]  csum;

   logic        accept;
   logic        start_load;
   logic [15:0] len_new;
   logic        last_byte_of_word;
   logic        last_word;

   assign accept            = in_valid && in_ready;
   assign start_load        = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign len_new           = {len_reg[15:8], in_data};
   assign last_byte_of_word = (byte_idx == 2'd3);
   assign last_word         = (word_cnt == len_reg - 16'd1);
   assign words_loaded      = word_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic; mid-stream start pulses are ignored
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_LEN_HI;
         S_LEN_HI: if (accept) state_next = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_new == 16'd0)      state_next = S_CHECK;
               else if (len_new > MAX_N)  state_next = S_ERROR;
               else                       state_next = S_DATA;
            end
         end
         S_DATA:   if (accept && last_byte_of_word && last_word) state_next = S_CHECK;
         S_CHECK:  if (accept) state_next = (in_data == csum) ? S_DONE : S_ERROR;
         S_DONE,
         S_ERROR:  if (start) state_next = S_LEN_HI;
         default:  state_next = S_IDLE;
      endcase
   end

   // Datapath: handshake, word assembly, write strobe, checksum and status
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= 32'h0;
         imem_wdata <= 32'h0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         len_reg    <= 16'h0;
         word_cnt   <= 16'h0;
         byte_idx   <= 2'd0;
         word_sr    <= 24'h0;
         csum       <= 8'h0;
      end else begin
         in_ready <= (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                     (state_next == S_DATA)   || (state_next == S_CHECK);
         imem_we  <= 1'b0;

         if (start_load) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_hold  <= 1'b1;
            word_cnt  <= 16'h0;
            byte_idx  <= 2'd0;
            csum      <= 8'h0;
         end

         if (accept) begin
            csum <= csum ^ in_data;
            case (state)
               S_LEN_HI: len_reg[15:8] <= in_data;
               S_LEN_LO: begin
                  len_reg[7:0] <= in_data;
                  if (len_new > MAX_N) load_err <= 1'b1;
               end
               S_DATA: begin
                  word_sr  <= {word_sr[15:0], in_data};
                  byte_idx <= byte_idx + 2'd1;
                  if (last_byte_of_word) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                     imem_wdata <= {word_sr, in_data};
                     word_cnt   <= word_cnt + 16'd1;
                  end
               end
               S_CHECK: begin
                  if (in_data == csum) begin
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     load_err  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
      .words_loaded(words_loaded)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  stim_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected-write queue
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", imem_addr, e[63:32]);
               chk("write_data", imem_wdata, e[31:0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no end expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         ok = in_ready;
         step();
         if (ok) break;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL handshake_timeout: got in_ready 0 expected 1 within 50 cycles");
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_stim(input bit gaps, input bit mid_start);
      for (int i = 0; i < stim_q.size(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) step();
         if (mid_start && i == 5) pulse_start();
         send_byte(stim_q[i]);
      end
   endtask

   task automatic load_std(input logic [7:0] last);
      stim_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                 8'h12, 8'h34, 8'h56, 8'h78, last};
      exp_q.push_back({32'h0000_0000, 32'hDEADBEEF});
      exp_q.push_back({32'h0000_0004, 32'h12345678});
   endtask

   task automatic check_result(input string tag, input logic done, input logic err,
                               input logic hold, input logic [15:0] words);
      chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
      chk({tag, "_load_err"},  {31'd0, load_err},  {31'd0, err});
      chk({tag, "_cpu_hold"},  {31'd0, cpu_hold},  {31'd0, hold});
      chk({tag, "_words"},     {16'd0, words_loaded}, {16'd0, words});
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
      chk({tag, "_pending"},   exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
      chk({tag, "_imem_we"},   {31'd0, imem_we},   32'd0);
      chk({tag, "_imem_addr"}, imem_addr,          32'd0);
      chk({tag, "_imem_wdata"}, imem_wdata,        32'd0);
      chk({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd1);
      chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
      chk({tag, "_load_err"},  {31'd0, load_err},  32'd0);
      chk({tag, "_words"},     {16'd0, words_loaded}, 32'd0);
   endtask

   // Directed stimulus
   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      step(); step();
      reset = 1'b0;
      check_reset_values("reset");

      // 1: good 2-word load
      load_std(8'h28);
      pulse_start();
      send_stim(1'b0, 1'b0);
      check_result("t1", 1'b1, 1'b0, 1'b0, 16'd2);

      // 2: bad checksum
      load_std(8'h29);
      pulse_start();
      send_stim(1'b0, 1'b0);
      check_result("t2", 1'b0, 1'b1, 1'b1, 16'd2);

      // 3: empty load
      stim_q = '{8'h00, 8'h00, 8'h00};
      pulse_start();
      send_stim(1'b0, 1'b0);
      check_result("t3", 1'b1, 1'b0, 1'b0, 16'd0);

      // 4: oversize count, then a good reload
      stim_q = '{8'h01, 8'h01};
      pulse_start();
      send_stim(1'b0, 1'b0);
      check_result("t4", 1'b0, 1'b1, 1'b1, 16'd0);
      stim_q = '{8'h00, 8'h00, 8'h00};
      pulse_start();
      send_stim(1'b0, 1'b0);
      check_result("t4_reload", 1'b1, 1'b0, 1'b0, 16'd0);

      // 5: pre-start bytes, gaps, and a start pulse during DATA
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_prestart_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      in_valid = 1'b0;
      load_std(8'h28);
      pulse_start();
      send_stim(1'b1, 1'b1);
      check_result("t5", 1'b1, 1'b0, 1'b0, 16'd2);

      // 6: reset after six bytes; word 0 is written before the reset edge
      stim_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp_q.push_back({32'h0000_0000, 32'hDEADBEEF});
      pulse_start();
      send_stim(1'b0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_values("t6_reset");
      chk("t6_word0_written", exp_q.size(), 32'd0);
      load_std(8'h28);
      pulse_start();
      send_stim(1'b0, 1'b0);
      check_result("t6_reload", 1'b1, 1'b0, 1'b0, 16'd2);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
